// File: rtl/mont_mul_if.sv
// Request/result handshake bundle shared by the x25519 arithmetic blocks.
interface mont_mul_if #(
  parameter int unsigned N = 255
);
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] M;
  logic [N-1:0] R;
  logic         req_valid;
  logic         req_ready;
  logic         req_busy;
  logic         res_valid;
  logic         res_ready;

  modport master (
    output A, B, M, req_valid, res_ready,
    input  R, req_ready, req_busy, res_valid
  );

  modport slave (
    input  A, B, M, req_valid, res_ready,
    output R, req_ready, req_busy, res_valid
  );
endinterface

// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: R = A*B*2^-N mod M, one bit of A per clock.
module mont_mul #(
  parameter int unsigned N = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  mont_mul_if.slave bus
);

  localparam int unsigned SW = N + 2;
  localparam int unsigned IW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_LOOP,
    S_FINAL,
    S_POST
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [N-1:0]  rm_q, rm_d;
  logic [N-1:0]  r_q, r_d;
  logic [SW-1:0] s_q, s_d;
  logic [IW-1:0] i_q, i_d;
  logic          req_ready_q, req_ready_d;
  logic          req_busy_q, req_busy_d;
  logic          res_valid_q, res_valid_d;

  logic [SW-1:0] t_add;
  logic [SW-1:0] t_red;
  logic          s_ge_m;

  // One Montgomery step; rA is shifted right so its current bit is always bit 0.
  always_comb begin
    t_add  = s_q + (ra_q[0] ? {2'b00, rb_q} : {SW{1'b0}});
    t_red  = t_add[0] ? (t_add + {2'b00, rm_q}) : t_add;
    s_ge_m = (s_q >= {2'b00, rm_q});
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rm_d        = rm_q;
    r_d         = r_q;
    s_d         = s_q;
    i_d         = i_q;
    req_ready_d = req_ready_q;
    req_busy_d  = req_busy_q;
    res_valid_d = res_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          ra_d        = bus.A;
          rb_d        = bus.B;
          rm_d        = bus.M;
          req_ready_d = 1'b1;
          req_busy_d  = 1'b1;
          state_d     = S_READY;
        end
      end
      S_READY: begin
        req_ready_d = 1'b0;
        s_d         = '0;
        i_d         = '0;
        state_d     = S_LOOP;
      end
      S_LOOP: begin
        s_d  = t_red >> 1;
        ra_d = ra_q >> 1;
        i_d  = i_q + IW'(1);
        if (i_q == IW'(N - 1)) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        r_d         = s_ge_m ? N'(s_q - {2'b00, rm_q}) : N'(s_q);
        res_valid_d = 1'b1;
        req_busy_d  = 1'b0;
        state_d     = S_POST;
      end
      S_POST: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      rm_q        <= '0;
      r_q         <= '0;
      s_q         <= '0;
      i_q         <= '0;
      req_ready_q <= 1'b0;
      req_busy_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rm_q        <= rm_d;
      r_q         <= r_d;
      s_q         <= s_d;
      i_q         <= i_d;
      req_ready_q <= req_ready_d;
      req_busy_q  <= req_busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign bus.R         = r_q;
  assign bus.req_ready = req_ready_q;
  assign bus.req_busy  = req_busy_q;
  assign bus.res_valid = res_valid_q;

endmodule
